// File: rtl/player_input_debouncer_pkg.sv
// Shared definitions for the player button debouncer: synchronizer depth,
// per-channel FSM state encodings and a small state-decode helper.
package player_input_debouncer_pkg;

  localparam int SYNC_DEPTH = 2;

  localparam logic [1:0] ST_RELEASED        = 2'd0;
  localparam logic [1:0] ST_CONFIRM_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED         = 2'd2;
  localparam logic [1:0] ST_CONFIRM_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    RELEASED        = ST_RELEASED,
    CONFIRM_PRESS   = ST_CONFIRM_PRESS,
    PRESSED         = ST_PRESSED,
    CONFIRM_RELEASE = ST_CONFIRM_RELEASE
  } debState_e;

  // The debounced level stays high while a release is still being confirmed.
  function automatic logic isDown(input debState_e s);
    return (s == PRESSED) || (s == CONFIRM_RELEASE);
  endfunction

endpackage

// File: rtl/player_input_debouncer_channel.sv
// One debounce path: inverting 2-flop synchronizer feeding a confirm-counter
// FSM with registered level and press-pulse outputs.
module debounce_channel
  import player_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n_in,
  output logic level_out,
  output logic press_out
);

  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sample;
  debState_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  level_q, press_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], ~raw_n_in};
    end
  end

  assign sample = sync_q[SYNC_DEPTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (sample) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!sample) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sample) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (sample) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge the FSM accepts a level, with no extra cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= isDown(state_d);
      press_q <= (state_q == CONFIRM_PRESS) && (state_d == PRESSED);
    end
  end

  assign level_out = level_q;
  assign press_out = press_q;

endmodule

// File: rtl/player_input_debouncer.sv
// Two-player button front end: one independent debounce channel per button,
// no shared state and no arbitration between players.
module player_input_debouncer
  import player_input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_n_in,
  input  logic btn2_n_in,
  output logic req1_out,
  output logic req2_out,
  output logic press1_out,
  output logic press2_out
);

  debounce_channel #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_chan1 (
    .clk      (clk),
    .reset    (reset),
    .raw_n_in (btn1_n_in),
    .level_out(req1_out),
    .press_out(press1_out)
  );

  debounce_channel #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_chan2 (
    .clk      (clk),
    .reset    (reset),
    .raw_n_in (btn2_n_in),
    .level_out(req2_out),
    .press_out(press2_out)
  );

endmodule

// File: tb/tb_player_input_debouncer.sv
// Scoreboard bench for player_input_debouncer with DEBOUNCE_COUNT=4: each
// stimulus cycle queues the hand-computed {req1,req2,press1,press2} expected.
module tb_player_input_debouncer;

  localparam int DEBOUNCE_COUNT = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn1_n_in = 1'b1;
  logic btn2_n_in = 1'b1;
  logic req1_out, req2_out, press1_out, press2_out;

  typedef struct {
    logic [3:0] expVal;
    string      name;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int checksTotal  = 0;
  int checksPassed = 0;

  player_input_debouncer #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn1_n_in (btn1_n_in),
    .btn2_n_in (btn2_n_in),
    .req1_out  (req1_out),
    .req2_out  (req2_out),
    .press1_out(press1_out),
    .press2_out(press2_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dutVec();
    return {req1_out, req2_out, press1_out, press2_out};
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] required);
    checksTotal++;
    if (actual === required) checksPassed++;
    else $display("[TB] FAIL %s: actual {req1,req2,press1,press2}=%b required=%b at %0t",
                  name, actual, required, $time);
  endtask

  // Drives one cycle of inputs at the falling edge; the queued value is what
  // the outputs must show just after the following rising edge.
  task automatic applyStimulus(input logic rst, input logic b1, input logic b2,
                               input logic [3:0] expVal, input string name);
    @(negedge clk);
    reset     = rst;
    btn1_n_in = b1;
    btn2_n_in = b2;
    sbQ.push_back('{expVal, name});
  endtask

  task automatic applyStimulusN(input int n, input logic rst, input logic b1, input logic b2,
                                input logic [3:0] expVal, input string name);
    for (int i = 0; i < n; i++) applyStimulus(rst, b1, b2, expVal, name);
  endtask

  always @(posedge clk) begin : monitor
    sbEntry_t e;
    #1;
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput(e.name, dutVec(), e.expVal);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 checkOutput("reset_state_async", dutVec(), 4'b0000);
    applyStimulusN(2, 1, 1, 1, 4'b0000, "reset_hold");
    applyStimulusN(3, 0, 1, 1, 4'b0000, "idle");

    // Single press on player 1: accepted on edge 2+DEBOUNCE_COUNT.
    applyStimulusN(5, 0, 0, 1, 4'b0000, "p1_confirm");
    applyStimulus (0, 0, 1, 4'b1010, "p1_accept");
    applyStimulusN(4, 0, 0, 1, 4'b1000, "p1_held");

    // Two-cycle bounce while pressed must not drop the level or re-pulse.
    applyStimulusN(2, 0, 1, 1, 4'b1000, "p1_bounce_hi");
    applyStimulusN(6, 0, 0, 1, 4'b1000, "p1_bounce_recover");
    applyStimulusN(5, 0, 1, 1, 4'b1000, "p1_release_confirm");
    applyStimulus (0, 1, 1, 4'b0000, "p1_released");
    applyStimulusN(3, 0, 1, 1, 4'b0000, "idle");

    // Three agreeing samples are one short of acceptance.
    applyStimulusN(3, 0, 0, 1, 4'b0000, "p1_short_press");
    applyStimulusN(6, 0, 1, 1, 4'b0000, "p1_short_after");
    applyStimulusN(1, 0, 1, 0, 4'b0000, "p2_glitch");
    applyStimulusN(5, 0, 1, 1, 4'b0000, "p2_glitch_after");

    // Simultaneous press and release on both channels.
    applyStimulusN(5, 0, 0, 0, 4'b0000, "both_confirm");
    applyStimulus (0, 0, 0, 4'b1111, "both_accept");
    applyStimulusN(3, 0, 0, 0, 4'b1100, "both_held");
    applyStimulusN(5, 0, 1, 1, 4'b1100, "both_release_confirm");
    applyStimulus (0, 1, 1, 4'b0000, "both_released");
    applyStimulusN(3, 0, 1, 1, 4'b0000, "idle");

    // Staggered: player 2 first, player 1 two cycles later.
    applyStimulusN(2, 0, 1, 0, 4'b0000, "stag_p2_confirm");
    applyStimulusN(3, 0, 0, 0, 4'b0000, "stag_both_confirm");
    applyStimulus (0, 0, 0, 4'b0101, "stag_p2_accept");
    applyStimulus (0, 0, 0, 4'b0100, "stag_p1_confirm");
    applyStimulus (0, 0, 0, 4'b1110, "stag_p1_accept");
    applyStimulusN(2, 0, 0, 0, 4'b1100, "stag_both_held");
    applyStimulusN(5, 0, 0, 1, 4'b1100, "stag_p2_release_confirm");
    applyStimulusN(3, 0, 0, 1, 4'b1000, "stag_p2_released");
    applyStimulusN(5, 0, 1, 1, 4'b1000, "stag_p1_release_confirm");
    applyStimulusN(3, 0, 1, 1, 4'b0000, "stag_p1_released");

    // Long hold of 20 cycles, then release with no pulse on release.
    applyStimulusN(5,  0, 0, 1, 4'b0000, "long_confirm");
    applyStimulus (0, 0, 1, 4'b1010, "long_accept");
    applyStimulusN(14, 0, 0, 1, 4'b1000, "long_held");
    applyStimulusN(5,  0, 1, 1, 4'b1000, "long_release_confirm");
    applyStimulusN(4,  0, 1, 1, 4'b0000, "long_released");

    // Reset landing in CONFIRM_PRESS with cnt=2, button kept held.
    applyStimulusN(4, 0, 0, 1, 4'b0000, "rst_confirm_prep");
    @(posedge clk);
    #3 reset = 1'b1;
    #1 checkOutput("reset_async_confirm", dutVec(), 4'b0000);
    applyStimulusN(2, 1, 0, 1, 4'b0000, "rst_confirm_hold");
    applyStimulusN(5, 0, 0, 1, 4'b0000, "post_reset_confirm");
    applyStimulus (0, 0, 1, 4'b1010, "post_reset_accept");
    applyStimulusN(3, 0, 0, 1, 4'b1000, "post_reset_held");

    // Reset while pressed clears the level without waiting for a clock.
    @(posedge clk);
    #3 reset = 1'b1;
    #1 checkOutput("reset_async_pressed", dutVec(), 4'b0000);
    applyStimulusN(2, 1, 0, 1, 4'b0000, "rst_pressed_hold");
    applyStimulusN(6, 0, 1, 1, 4'b0000, "post_reset_idle");

    for (int i = 0; i < 10; i++) begin
      if (sbQ.size() == 0) break;
      @(negedge clk);
    end
    if (sbQ.size() != 0) begin
      checksTotal++;
      $display("[TB] FAIL scoreboard_drain: actual pending=%0d required=0", sbQ.size());
    end

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
